cdb_arbiter: RTL and testbench

CDB_ARBITER -- requirements
Module: cdb_arbiter

---
 rtl/cdb_arbiter.sv | 97 +++++++++
 tb/tb_cdb_arbiter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: picks one finished functional unit per cycle and broadcasts its result next cycle.
// Define CDB_ROUND_ROBIN_EN for rotating priority; otherwise fixed priority, where the lowest index wins.
module cdb_arbiter #(
   parameter int NUM_FU       = 5,
   parameter int DATA_WIDTH   = 32,
   parameter int ROB_IX_WIDTH = 3
) (
   input  logic                                 clk_in,
   input  logic                                 rst_in,
   input  logic                                 flush_in,
   input  logic [NUM_FU-1:0]                    fu_valid_in,
   input  logic [NUM_FU-1:0][DATA_WIDTH-1:0]    fu_data_in,
   input  logic [NUM_FU-1:0][ROB_IX_WIDTH-1:0]  fu_rob_ix_in,
   output logic [NUM_FU-1:0]                    fu_read_out,
   output logic                                 cdb_valid_out,
   output logic [DATA_WIDTH-1:0]                cdb_value_out,
   output logic [ROB_IX_WIDTH-1:0]              cdb_rob_ix_out,
   output logic [NUM_FU-1:0]                    cdb_fu_out
);

   localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

   logic [PTR_W-1:0]        start_ix;
   logic [PTR_W-1:0]        scan_ix;
   logic                    win_found;
   logic [NUM_FU-1:0]       win_onehot;
   logic [DATA_WIDTH-1:0]   win_data;
   logic [ROB_IX_WIDTH-1:0] win_rob;
   logic                    grant_ok;

`ifdef CDB_ROUND_ROBIN_EN
   logic [PTR_W-1:0] ptr;
   logic [PTR_W-1:0] win_ix;
   assign start_ix = ptr;
`else
   assign start_ix = '0;
`endif

   // Scan upward from the start index (modulo NUM_FU); the first requester found wins.
   always_comb begin
      win_found  = 1'b0;
      win_onehot = '0;
      win_data   = '0;
      win_rob    = '0;
      scan_ix    = '0;
`ifdef CDB_ROUND_ROBIN_EN
      win_ix     = '0;
`endif
      for (int i = 0; i < NUM_FU; i++) begin
         scan_ix = PTR_W'((int'(start_ix) + i) % NUM_FU);
         if (!win_found && fu_valid_in[scan_ix]) begin
            win_found           = 1'b1;
            win_onehot[scan_ix] = 1'b1;
            win_data            = fu_data_in[scan_ix];
            win_rob             = fu_rob_ix_in[scan_ix];
`ifdef CDB_ROUND_ROBIN_EN
            win_ix              = scan_ix;
`endif
         end
      end
   end

   assign grant_ok    = win_found && !rst_in && !flush_in;
   assign fu_read_out = grant_ok ? win_onehot : '0;

`ifdef CDB_ROUND_ROBIN_EN
   // Pointer moves just past the winner; flush or idle cycles leave it alone.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         ptr <= '0;
      end else if (grant_ok) begin
         if (win_ix == PTR_W'(NUM_FU - 1))
            ptr <= '0;
         else
            ptr <= win_ix + PTR_W'(1);
      end
   end
`endif

   // Value and ROB index hold across idle cycles; only valid and FU identity drop.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         cdb_valid_out  <= 1'b0;
         cdb_value_out  <= '0;
         cdb_rob_ix_out <= '0;
         cdb_fu_out     <= '0;
      end else begin
         cdb_valid_out <= grant_ok;
         cdb_fu_out    <= fu_read_out;
         if (grant_ok) begin
            cdb_value_out  <= win_data;
            cdb_rob_ix_out <= win_rob;
         end
      end
   end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Randomized and directed checks of cdb_arbiter against a distance-based priority model.
// The model reads CDB_ROUND_ROBIN_EN the same way the design does.
module tb_cdb_arbiter;

   localparam int N  = 5;
   localparam int DW = 32;
   localparam int RW = 3;

   logic                    clk_in = 1'b0;
   logic                    rst_in;
   logic                    flush_in;
   logic [N-1:0]            fu_valid_in;
   logic [N-1:0][DW-1:0]    fu_data_in;
   logic [N-1:0][RW-1:0]    fu_rob_ix_in;
   logic [N-1:0]            fu_read_out;
   logic                    cdb_valid_out;
   logic [DW-1:0]           cdb_value_out;
   logic [RW-1:0]           cdb_rob_ix_out;
   logic [N-1:0]            cdb_fu_out;

   int checkCount = 0;
   int passCount  = 0;

   int           mPtr   = 0;
   logic         mValid = 1'b0;
   logic [DW-1:0] mValue = '0;
   logic [RW-1:0] mRob   = '0;
   logic [N-1:0]  mFu    = '0;
   int           lastGrant;

   always #5 clk_in = ~clk_in;

   cdb_arbiter #(.NUM_FU(N), .DATA_WIDTH(DW), .ROB_IX_WIDTH(RW)) dut (
      .clk_in         (clk_in),
      .rst_in         (rst_in),
      .flush_in       (flush_in),
      .fu_valid_in    (fu_valid_in),
      .fu_data_in     (fu_data_in),
      .fu_rob_ix_in   (fu_rob_ix_in),
      .fu_read_out    (fu_read_out),
      .cdb_valid_out  (cdb_valid_out),
      .cdb_value_out  (cdb_value_out),
      .cdb_rob_ix_out (cdb_rob_ix_out),
      .cdb_fu_out     (cdb_fu_out)
   );

   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      checkCount++;
      if (actual === expected)
         passCount++;
      else
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
   endtask

   // Winner is the requester with the smallest upward distance from the priority start.
   function automatic int modelWinner(input logic [N-1:0] req);
      int best     = -1;
      int bestDist = N;
      int start;
`ifdef CDB_ROUND_ROBIN_EN
      start = mPtr;
`else
      start = 0;
`endif
      for (int g = 0; g < N; g++) begin
         if (req[g] && ((g - start + N) % N) < bestDist) begin
            bestDist = (g - start + N) % N;
            best     = g;
         end
      end
      return best;
   endfunction

   task automatic applyStimulus(input logic r, input logic f, input logic [N-1:0] v);
      int w;
      logic [N-1:0] expGrant;
      @(negedge clk_in);
      rst_in      = r;
      flush_in    = f;
      fu_valid_in = v;
      #1;
      w = (r || f) ? -1 : modelWinner(v);
      expGrant = (w < 0) ? '0 : N'(1 << w);
      checkOutput("fu_read_out", 64'(fu_read_out), 64'(expGrant));
      @(posedge clk_in);
      if (r) begin
         mValid = 1'b0; mValue = '0; mRob = '0; mFu = '0; mPtr = 0;
      end else if (w >= 0) begin
         mValid = 1'b1;
         mValue = fu_data_in[w];
         mRob   = fu_rob_ix_in[w];
         mFu    = expGrant;
`ifdef CDB_ROUND_ROBIN_EN
         mPtr   = (w + 1) % N;
`endif
      end else begin
         mValid = 1'b0;
         mFu    = '0;
      end
      #1;
      checkOutput("cdb_valid", 64'(cdb_valid_out), 64'(mValid));
      checkOutput("cdb_value", 64'(cdb_value_out), 64'(mValue));
      checkOutput("cdb_rob_ix", 64'(cdb_rob_ix_out), 64'(mRob));
      if (mValid)
         checkOutput("cdb_fu", 64'(cdb_fu_out), 64'(mFu));
      lastGrant = w;
   endtask

   initial begin
      logic [N-1:0] pending;
      int expSeq[6];
      rst_in = 1'b1; flush_in = 1'b0; fu_valid_in = '0;
      for (int i = 0; i < N; i++) begin
         fu_data_in[i]   = DW'(32'h100 * (i + 1));
         fu_rob_ix_in[i] = RW'(i);
      end

      // Reset state, and no grant while reset is held even with all FUs requesting.
      applyStimulus(1'b1, 1'b0, '0);
      applyStimulus(1'b1, 1'b0, 5'b11111);

      // Single ALU result.
      fu_data_in[0] = 32'h0000_0007; fu_rob_ix_in[0] = 3'd3;
      applyStimulus(1'b0, 1'b0, 5'b00001);
      checkOutput("single_value", 64'(cdb_value_out), 64'h7);
      checkOutput("single_rob", 64'(cdb_rob_ix_out), 64'h3);
      checkOutput("single_fu", 64'(cdb_fu_out), 64'h1);

      // All FUs requesting for six cycles.
      applyStimulus(1'b1, 1'b0, '0);
`ifdef CDB_ROUND_ROBIN_EN
      expSeq = '{0, 1, 2, 3, 4, 0};
`else
      expSeq = '{0, 0, 0, 0, 0, 0};
`endif
      for (int c = 0; c < 6; c++) begin
         applyStimulus(1'b0, 1'b0, 5'b11111);
         checkOutput("all_req_seq", 64'(lastGrant), 64'(expSeq[c]));
      end

      // Pointer at 4 with FU4 and FU0 requesting: wrap.
      applyStimulus(1'b1, 1'b0, '0);
      applyStimulus(1'b0, 1'b0, 5'b01000);
      applyStimulus(1'b0, 1'b0, 5'b10001);
`ifdef CDB_ROUND_ROBIN_EN
      checkOutput("wrap_first", 64'(lastGrant), 64'd4);
`else
      checkOutput("wrap_first", 64'(lastGrant), 64'd0);
`endif
      applyStimulus(1'b0, 1'b0, 5'b10001);
`ifdef CDB_ROUND_ROBIN_EN
      checkOutput("wrap_second", 64'(lastGrant), 64'd0);
`else
      checkOutput("wrap_second", 64'(lastGrant), 64'd0);
`endif

      // Flush squashes the request; it is granted once flush drops.
      applyStimulus(1'b0, 1'b1, 5'b00100);
      checkOutput("flush_valid", 64'(cdb_valid_out), 64'h0);
      applyStimulus(1'b0, 1'b0, 5'b00100);
      checkOutput("after_flush", 64'(lastGrant), 64'd2);

      // Reset lands during FU1's broadcast; FU1 keeps requesting and wins again.
      applyStimulus(1'b1, 1'b0, '0);
      applyStimulus(1'b0, 1'b0, 5'b00010);
      applyStimulus(1'b1, 1'b0, 5'b00010);
      checkOutput("reset_mid_valid", 64'(cdb_valid_out), 64'h0);
      applyStimulus(1'b0, 1'b0, 5'b00010);
      checkOutput("regrant_fu1", 64'(lastGrant), 64'd1);

      // Random traffic: FUs hold requests until read, with occasional flush and reset.
      pending = '0;
      for (int c = 0; c < 400; c++) begin
         logic r, f;
         pending = pending | N'($urandom);
         r = ($urandom_range(0, 49) == 0);
         f = ($urandom_range(0, 9) == 0);
         applyStimulus(r, f, pending);
         if (lastGrant >= 0) begin
            pending[lastGrant]      = 1'b0;
            fu_data_in[lastGrant]   = DW'($urandom);
            fu_rob_ix_in[lastGrant] = RW'($urandom);
         end
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
